linebuffer_ring: RTL and testbench
==================================

# linebuffer_ring

Parametrised N-bank line buffer between the tile renderer (draw side) and the VGA pixel scanout (display side). Banks form a ring: one is displayed, one is drawn into, and a bank released from display is cleared in the background before it can be drawn into again. Draw writes are tile-wide with per-pixel masking, so transparent pixels are skipped. Bank rotation uses a request/acknowledge handshake instead of a free-running select.

## Interface
Parameters:
- NUM_BANKS, 2, bank count (≥2)
- PIX_W, 16, bits per pixel
- TILE_PIX, 16, pixels per tile word
- LINE_PIX, 640, pixels per line; must be a multiple of TILE_PIX
- CLEAR_VALUE, 16'h0000, pixel value written by clear

Derived: TILES = LINE_PIX/TILE_PIX; TILE_W = PIX_W*TILE_PIX; TILE_AW = $clog2(TILES); PIX_AW = $clog2(LINE_PIX); BANK_W = $clog2(NUM_BANKS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- swap_req  in  1  level request to rotate banks
- swap_ack  out  1  one-cycle pulse: rotation accepted this cycle
- swap_ready  out  1  rotation can be accepted (FSM in IDLE)
- draw_ready  out  1  draw bank is writable
- disp_addr  in  PIX_AW  display pixel address
- disp_q  out  PIX_W  display pixel data, 1-cycle latency
- draw_addr  in  TILE_AW  draw tile address
- draw_data  in  TILE_W  draw tile data, pixel i at bits [i*PIX_W +: PIX_W]
- draw_mask  in  TILE_PIX  per-pixel write enable
- draw_we  in  1  draw write strobe
- draw_q  out  TILE_W  draw tile read data, 1-cycle latency
- disp_bank  out  BANK_W  current display bank index
- draw_bank  out  BANK_W  current draw bank index

## Operation
- Reset values: disp_bank=0, draw_bank=1, swap_ack=0, the state register set as described under Configuration.
- Rotation: accepted when swap_req && swap_ready. At that edge disp_bank ← draw_bank and draw_bank ← (draw_bank+1) mod NUM_BANKS. swap_ack pulses in the same cycle. The old display bank becomes the clear target.
- FSM states: INIT (clear all banks), IDLE, CLEAR (clear one bank). IDLE→CLEAR on an accepted swap. CLEAR→IDLE after writing address TILES-1. INIT→IDLE after address TILES-1.
- Clear: an up-counter clr_addr from 0 to TILES-1 writes CLEAR_VALUE to every pixel of the target bank's tile port, one word per cycle, with the mask all ones.
- draw_ready = !(state==INIT || (state==CLEAR && clear target==draw_bank)). For NUM_BANKS=2 it is low for the whole clear. For NUM_BANKS≥3 it stays high after rotation.
- A draw_we while draw_ready=0 is dropped with no side effect.
- Masked write: only lanes with draw_mask[i]=1 are written. draw_mask=0 with draw_we=1 is a no-op.
- Display port is read-only.

## Timing
- Bank mapping is registered. A swap accepted at edge E affects reads and writes from the cycle after E.
- A draw write in the acceptance cycle lands in the old draw bank.
- disp_q and draw_q are valid one cycle after their address is presented, taken from the bank mapped when the address was presented.
- CLEAR occupies exactly TILES cycles; swap_ready returns high TILES cycles after swap_ack.
- A swap_req held during CLEAR or INIT waits. No request is lost or queued twice.
- Asserting reset mid-clear aborts the clear and restarts INIT.
- Bank index wrap: (NUM_BANKS-1)+1 → 0.

## Configuration
- LINEBUF_AUTOCLEAR_EN defined: INIT/CLEAR FSM present as above. Reset enters INIT.
- LINEBUF_AUTOCLEAR_EN undefined: no FSM and no clear counter.
  - Reset enters IDLE.
  - swap_ready and draw_ready are tied to 1; every swap_req is acknowledged the same cycle.
  - Released banks keep their contents, and RAM contents after reset are undefined.

## Structure
- Package linebuffer_pkg holds:
  - state enum lb_state_e {INIT, IDLE, CLEAR}
  - default PIX_W/TILE_PIX/LINE_PIX constants
  - a pixel-lane extract function
- Sub-module linebuffer_bank is a true dual-port RAM:
  - port A: TILE_W wide with TILE_PIX lane enables
  - port B: PIX_W read
  - both ports single clock, 1-cycle read latency
  - instantiated NUM_BANKS times via generate
- Port steering is registered-index muxing in the top level.

## Test plan
Defaults: NUM_BANKS=2, LINE_PIX=640, TILE_PIX=16, TILES=40.
- Reset with macro: swap_ready=0 and draw_ready=0 for 40 cycles → afterwards every disp_q reads 16'h0000; swap_ready=1.
- Draw write addr 3 with lanes 0..15 set to 16'hA5A5 and mask 16'hFFFF, then swap → after ack, disp_addr 48..63 return 16'hA5A5 one cycle later; disp_bank=1, draw_bank=0.
- Masked write mask=16'h0001 with data 16'h1234 in lane 0, over a previous 16'hA5A5 line → draw_q lane 0=16'h1234, lanes 1..15=16'hA5A5.
- swap_req held high continuously → swap_ack pulses exactly every 41 cycles; a draw_we during clear leaves the cleared bank all 16'h0000.
- NUM_BANKS=3: three swaps → disp_bank sequence 1,2,0; draw_ready stays 1 immediately after each ack.
- Reset asserted at clear address 20 → INIT restarts; all banks read 16'h0000 after 40 cycles.

Source files
------------

// File: rtl/linebuffer_pkg.sv
// Shared state type, default geometry and pixel-lane helper for the linebuffer ring.
package linebuffer_pkg;

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} lb_state_e;

  localparam int unsigned DEF_PIX_W    = 16;
  localparam int unsigned DEF_TILE_PIX = 16;
  localparam int unsigned DEF_LINE_PIX = 640;
  localparam int unsigned DEF_TILE_W   = DEF_PIX_W * DEF_TILE_PIX;

  function automatic logic [DEF_PIX_W-1:0] pix_lane(input logic [DEF_TILE_W-1:0] tile,
                                                    input int unsigned lane);
    return tile[lane*DEF_PIX_W +: DEF_PIX_W];
  endfunction

endpackage

// File: rtl/linebuffer_if.sv
// Draw, display and swap-handshake signals between the renderer/scanout side and the ring.
interface linebuffer_if
  import linebuffer_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned PIX_W     = DEF_PIX_W,
  parameter int unsigned TILE_PIX  = DEF_TILE_PIX,
  parameter int unsigned LINE_PIX  = DEF_LINE_PIX
);
  localparam int unsigned TILES   = LINE_PIX / TILE_PIX;
  localparam int unsigned TILE_W  = PIX_W * TILE_PIX;
  localparam int unsigned TILE_AW = $clog2(TILES);
  localparam int unsigned PIX_AW  = $clog2(LINE_PIX);
  localparam int unsigned BANK_W  = $clog2(NUM_BANKS);

  logic                swap_req;
  logic                swap_ack;
  logic                swap_ready;
  logic                draw_ready;
  logic [PIX_AW-1:0]   disp_addr;
  logic [PIX_W-1:0]    disp_q;
  logic [TILE_AW-1:0]  draw_addr;
  logic [TILE_W-1:0]   draw_data;
  logic [TILE_PIX-1:0] draw_mask;
  logic                draw_we;
  logic [TILE_W-1:0]   draw_q;
  logic [BANK_W-1:0]   disp_bank;
  logic [BANK_W-1:0]   draw_bank;

  modport master (
    output swap_req, disp_addr, draw_addr, draw_data, draw_mask, draw_we,
    input  swap_ack, swap_ready, draw_ready, disp_q, draw_q, disp_bank, draw_bank
  );

  modport slave (
    input  swap_req, disp_addr, draw_addr, draw_data, draw_mask, draw_we,
    output swap_ack, swap_ready, draw_ready, disp_q, draw_q, disp_bank, draw_bank
  );

endinterface

// File: rtl/linebuffer_bank.sv
// One line bank: port A is a tile-wide read/write port with per-lane enables,
// port B is a single-pixel read port; both have one cycle of read latency.
module linebuffer_bank #(
  parameter int unsigned PIX_W    = 16,
  parameter int unsigned TILE_PIX = 16,
  parameter int unsigned TILES    = 40,
  parameter int unsigned TILE_W   = PIX_W * TILE_PIX,
  parameter int unsigned TILE_AW  = $clog2(TILES),
  parameter int unsigned PIX_AW   = $clog2(TILES * TILE_PIX),
  parameter int unsigned LANE_AW  = $clog2(TILE_PIX)
) (
  input  logic                clk,
  input  logic [TILE_AW-1:0]  a_addr,
  input  logic [TILE_W-1:0]   a_wdata,
  input  logic [TILE_PIX-1:0] a_we,
  output logic [TILE_W-1:0]   a_q,
  input  logic [PIX_AW-1:0]   b_addr,
  output logic [PIX_W-1:0]    b_q
);

  logic [TILE_W-1:0]  mem [TILES];
  logic [TILE_W-1:0]  a_q_q, a_q_d;
  logic [PIX_W-1:0]   b_q_q, b_q_d;
  logic [TILE_AW-1:0] b_tile;
  logic [LANE_AW-1:0] b_lane;

  assign b_tile = TILE_AW'(b_addr / PIX_AW'(TILE_PIX));
  assign b_lane = LANE_AW'(b_addr % PIX_AW'(TILE_PIX));

  always_comb begin
    a_q_d = mem[a_addr];
    b_q_d = mem[b_tile][b_lane*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TILE_PIX; i++) begin
      if (a_we[i]) mem[a_addr][i*PIX_W +: PIX_W] <= a_wdata[i*PIX_W +: PIX_W];
    end
    a_q_q <= a_q_d;
    b_q_q <= b_q_d;
  end

  assign a_q = a_q_q;
  assign b_q = b_q_q;

endmodule

// File: rtl/linebuffer_ring.sv
// N-bank line buffer ring: one bank displayed, one drawn, released banks rotate via swap handshake.
// Background clearing (INIT/CLEAR FSM) is built only when LINEBUF_AUTOCLEAR_EN is defined.
module linebuffer_ring
  import linebuffer_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned PIX_W       = DEF_PIX_W,
  parameter int unsigned TILE_PIX    = DEF_TILE_PIX,
  parameter int unsigned LINE_PIX    = DEF_LINE_PIX,
  parameter logic [PIX_W-1:0] CLEAR_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  linebuffer_if.slave  bus
);

  localparam int unsigned TILES   = LINE_PIX / TILE_PIX;
  localparam int unsigned TILE_W  = PIX_W * TILE_PIX;
  localparam int unsigned TILE_AW = $clog2(TILES);
  localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [BANK_W-1:0]  disp_bank_q, disp_bank_d, draw_bank_q, draw_bank_d;
  logic [BANK_W-1:0]  disp_sel_q, draw_sel_q;
  logic               swap_fire;
  logic               clr_all, clr_one;
  logic [TILE_AW-1:0] clr_addr;
  logic [BANK_W-1:0]  clr_bank;

  logic [TILE_AW-1:0]  a_addr  [NUM_BANKS];
  logic [TILE_W-1:0]   a_wdata [NUM_BANKS];
  logic [TILE_PIX-1:0] a_we    [NUM_BANKS];
  logic [TILE_W-1:0]   a_q     [NUM_BANKS];
  logic [PIX_W-1:0]    b_q     [NUM_BANKS];

`ifdef LINEBUF_AUTOCLEAR_EN
  localparam logic [TILE_AW-1:0] LAST_TILE = TILE_AW'(TILES - 1);

  lb_state_e          state_q, state_d;
  logic [TILE_AW-1:0] clr_addr_q, clr_addr_d;
  logic [BANK_W-1:0]  clr_bank_q, clr_bank_d;

  assign bus.swap_ready = (state_q == IDLE);
  assign bus.draw_ready = !((state_q == INIT) || (state_q == CLEAR && clr_bank_q == draw_bank_q));
  assign clr_all  = (state_q == INIT);
  assign clr_one  = (state_q == CLEAR);
  assign clr_addr = clr_addr_q;
  assign clr_bank = clr_bank_q;

  // The bank leaving display becomes the clear target; INIT sweeps every bank at once.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_bank_d = clr_bank_q;
    unique case (state_q)
      INIT, CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_TILE) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
      IDLE: begin
        if (swap_fire) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          clr_bank_d = disp_bank_q;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
      clr_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_bank_q <= clr_bank_d;
    end
  end
`else
  assign bus.swap_ready = 1'b1;
  assign bus.draw_ready = 1'b1;
  assign clr_all  = 1'b0;
  assign clr_one  = 1'b0;
  assign clr_addr = '0;
  assign clr_bank = '0;
`endif

  assign swap_fire     = bus.swap_req && bus.swap_ready && !reset;
  assign bus.swap_ack  = swap_fire;
  assign bus.disp_bank = disp_bank_q;
  assign bus.draw_bank = draw_bank_q;

  always_comb begin
    disp_bank_d = disp_bank_q;
    draw_bank_d = draw_bank_q;
    if (swap_fire) begin
      disp_bank_d = draw_bank_q;
      draw_bank_d = (draw_bank_q == LAST_BANK) ? '0 : draw_bank_q + 1'b1;
    end
  end

  // Read-side selects are captured with the address so data follows the mapping at request time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bank_q <= '0;
      draw_bank_q <= BANK_W'(1);
      disp_sel_q  <= '0;
      draw_sel_q  <= BANK_W'(1);
    end else begin
      disp_bank_q <= disp_bank_d;
      draw_bank_q <= draw_bank_d;
      disp_sel_q  <= disp_bank_q;
      draw_sel_q  <= draw_bank_q;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      a_addr[b]  = bus.draw_addr;
      a_wdata[b] = bus.draw_data;
      a_we[b]    = '0;
      if (clr_all || (clr_one && clr_bank == BANK_W'(b))) begin
        a_addr[b]  = clr_addr;
        a_wdata[b] = {TILE_PIX{CLEAR_VALUE}};
        a_we[b]    = '1;
      end else if (bus.draw_we && bus.draw_ready && draw_bank_q == BANK_W'(b)) begin
        a_we[b]    = bus.draw_mask;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    linebuffer_bank #(
      .PIX_W    (PIX_W),
      .TILE_PIX (TILE_PIX),
      .TILES    (TILES)
    ) u_bank (
      .clk     (clk),
      .a_addr  (a_addr[g]),
      .a_wdata (a_wdata[g]),
      .a_we    (a_we[g]),
      .a_q     (a_q[g]),
      .b_addr  (bus.disp_addr),
      .b_q     (b_q[g])
    );
  end

  assign bus.disp_q = b_q[disp_sel_q];
  assign bus.draw_q = a_q[draw_sel_q];

endmodule

// File: tb/tb_linebuffer_ring.sv
// Directed scoreboard bench for linebuffer_ring with 2-bank and 3-bank instances;
// the clear-timing checks are compiled in when LINEBUF_AUTOCLEAR_EN is defined.
module tb_linebuffer_ring;
  import linebuffer_pkg::*;

  localparam int TW = 256;

  logic clk = 1'b0;
  logic reset;
  int   vecCount  = 0;
  int   missCount = 0;

  string          tagQ[$];
  logic [TW-1:0]  expQ[$];

  always #5 clk = ~clk;

  linebuffer_if #(.NUM_BANKS(2)) busA ();
  linebuffer_if #(.NUM_BANKS(3)) busB ();

  linebuffer_ring #(.NUM_BANKS(2)) dutA (.clk(clk), .reset(reset), .bus(busA.slave));
  linebuffer_ring #(.NUM_BANKS(3)) dutB (.clk(clk), .reset(reset), .bus(busB.slave));

  function automatic logic [TW-1:0] fillTile(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [TW-1:0] rampTile(input logic [15:0] base, input logic [15:0] step);
    logic [TW-1:0] t;
    for (int i = 0; i < 16; i++) t[i*16 +: 16] = 16'(base + step * 16'(i));
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input int tile, input logic [TW-1:0] data,
                               input logic [15:0] mask);
    if (sel == 0) begin
      busA.draw_addr = 6'(tile); busA.draw_data = data; busA.draw_mask = mask; busA.draw_we = 1'b1;
    end else begin
      busB.draw_addr = 6'(tile); busB.draw_data = data; busB.draw_mask = mask; busB.draw_we = 1'b1;
    end
    tick();
    busA.draw_we = 1'b0;
    busB.draw_we = 1'b0;
  endtask

  task automatic readDraw(input int sel, input int tile, input logic [TW-1:0] exp, input string tag);
    if (sel == 0) busA.draw_addr = 6'(tile); else busB.draw_addr = 6'(tile);
    tagQ.push_back(tag);
    expQ.push_back(exp);
    tick();
    checkOutput(tagQ.pop_front(), (sel == 0) ? busA.draw_q : busB.draw_q, expQ.pop_front());
  endtask

  task automatic readDisp(input int sel, input int addr, input logic [15:0] exp, input string tag);
    if (sel == 0) busA.disp_addr = 10'(addr); else busB.disp_addr = 10'(addr);
    tagQ.push_back(tag);
    expQ.push_back(TW'(exp));
    tick();
    checkOutput(tagQ.pop_front(), TW'((sel == 0) ? busA.disp_q : busB.disp_q), expQ.pop_front());
  endtask

  task automatic doSwap(input int sel, input int expDisp, input int expDraw, input string tag);
    if (sel == 0) busA.swap_req = 1'b1; else busB.swap_req = 1'b1;
    #1;
    checkOutput({tag, " swap_ack"}, TW'((sel == 0) ? busA.swap_ack : busB.swap_ack), TW'(1));
    tick();
    busA.swap_req = 1'b0;
    busB.swap_req = 1'b0;
    checkOutput({tag, " disp_bank"}, TW'((sel == 0) ? busA.disp_bank : busB.disp_bank), TW'(expDisp));
    checkOutput({tag, " draw_bank"}, TW'((sel == 0) ? busA.draw_bank : busB.draw_bank), TW'(expDraw));
  endtask

  task automatic waitReady(input int sel, input int budget, input string tag);
    int n = 0;
    while (((sel == 0) ? busA.swap_ready : busB.swap_ready) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, " swap_ready within budget"},
                TW'((sel == 0) ? busA.swap_ready : busB.swap_ready), TW'(1));
  endtask

`ifdef LINEBUF_AUTOCLEAR_EN
  task automatic waitLow(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      checkOutput({tag, " swap_ready low"}, TW'(busA.swap_ready), '0);
      checkOutput({tag, " draw_ready low"}, TW'(busA.draw_ready), '0);
      tick();
    end
  endtask

  task automatic checkHigh(input string tag);
    checkOutput({tag, " swap_ready high"}, TW'(busA.swap_ready), TW'(1));
    checkOutput({tag, " draw_ready high"}, TW'(busA.draw_ready), TW'(1));
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [TW-1:0] t3, pat5, pat0;
    int            ackCycles[$];
    int            expDisp;

    t3   = fillTile(16'hA5A5);
    t3[15:0]    = 16'h1234;
    t3[255:240] = 16'hBEEF;
    pat5 = rampTile(16'h0000, 16'h1111);
    pat0 = rampTile(16'h1000, 16'h0001);

    reset = 1'b1;
    busA.swap_req = 1'b1; busA.disp_addr = '0; busA.draw_addr = '0;
    busA.draw_data = '0;  busA.draw_mask = '0; busA.draw_we = 1'b0;
    busB.swap_req = 1'b0; busB.disp_addr = '0; busB.draw_addr = '0;
    busB.draw_data = '0;  busB.draw_mask = '0; busB.draw_we = 1'b0;
    tick();
    tick();
    checkOutput("reset disp_bank", TW'(busA.disp_bank), '0);
    checkOutput("reset draw_bank", TW'(busA.draw_bank), TW'(1));
    checkOutput("reset swap_ack with req held", TW'(busA.swap_ack), '0);
    busA.swap_req = 1'b0;
    reset = 1'b0;

`ifdef LINEBUF_AUTOCLEAR_EN
    waitLow(40, "init");
    checkHigh("init done");
    readDisp(0, 0, 16'h0000, "init disp addr 0");
    readDisp(0, 639, 16'h0000, "init disp addr 639");
    readDraw(0, 39, '0, "init draw tile 39");
`else
    checkOutput("swap_ready tied", TW'(busA.swap_ready), TW'(1));
    checkOutput("draw_ready tied", TW'(busA.draw_ready), TW'(1));
`endif

    applyStimulus(0, 3, fillTile(16'hA5A5), 16'hFFFF);
    applyStimulus(0, 5, pat5, 16'hFFFF);
    readDraw(0, 3, fillTile(16'hA5A5), "full tile write");
    applyStimulus(0, 3, {{15{16'hDEAD}}, 16'h1234}, 16'h0001);
    readDraw(0, 3, {{15{16'hA5A5}}, 16'h1234}, "mask lane 0");
    applyStimulus(0, 3, fillTile(16'hBEEF), 16'h8000);
    readDraw(0, 3, t3, "mask lane 15");
    applyStimulus(0, 3, fillTile(16'h0F0F), 16'h0000);
    readDraw(0, 3, t3, "empty mask no-op");
    readDraw(0, 5, pat5, "ramp tile");

    busA.draw_addr = 6'd7; busA.draw_data = fillTile(16'h7777);
    busA.draw_mask = 16'hFFFF; busA.draw_we = 1'b1;
    doSwap(0, 1, 0, "swap 1");
    busA.draw_we = 1'b0;

`ifdef LINEBUF_AUTOCLEAR_EN
    waitLow(39, "clear bank0");
    checkOutput("clear last swap_ready low", TW'(busA.swap_ready), '0);
    applyStimulus(0, 2, fillTile(16'hFFFF), 16'hFFFF);
    checkHigh("clear bank0 done");
    readDraw(0, 2, '0, "dropped draw during clear");
    readDraw(0, 39, '0, "cleared tile 39");
`endif

    for (int i = 0; i < 16; i++) readDisp(0, 48 + i, pix_lane(t3, i), "disp tile 3 lane");
    readDisp(0, 80, pix_lane(pat5, 0), "disp tile 5 lane 0");
    readDisp(0, 87, pix_lane(pat5, 7), "disp tile 5 lane 7");
    readDisp(0, 95, pix_lane(pat5, 15), "disp tile 5 lane 15");
    readDisp(0, 112, 16'h7777, "write in ack cycle hits old draw bank");

    applyStimulus(0, 0, pat0, 16'hFFFF);
    doSwap(0, 0, 1, "swap 2 wrap");
`ifdef LINEBUF_AUTOCLEAR_EN
    waitLow(40, "clear bank1");
    checkHigh("clear bank1 done");
`endif
    for (int i = 0; i < 4; i++) readDisp(0, i, pix_lane(pat0, i), "disp bank0 tile 0");
    readDisp(0, 15, 16'h100F, "disp bank0 tile 0 lane 15");

    doSwap(0, 1, 0, "swap 3");
`ifdef LINEBUF_AUTOCLEAR_EN
    readDisp(0, 48, 16'h0000, "released bank cleared lane 0");
    readDisp(0, 95, 16'h0000, "released bank cleared tile 5");
    readDisp(0, 112, 16'h0000, "released bank cleared tile 7");
    waitReady(0, 60, "after swap 3");

    busA.swap_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (busA.swap_ack === 1'b1) ackCycles.push_back(c);
      tick();
    end
    busA.swap_req = 1'b0;
    checkOutput("held req ack count", TW'(ackCycles.size()), TW'(3));
    checkOutput("held req first ack", TW'(ackCycles.size() > 0 ? ackCycles[0] : -1), '0);
    checkOutput("held req period 1",
                TW'(ackCycles.size() >= 2 ? ackCycles[1] - ackCycles[0] : -1), TW'(41));
    checkOutput("held req period 2",
                TW'(ackCycles.size() >= 3 ? ackCycles[2] - ackCycles[1] : -1), TW'(41));
    waitReady(0, 60, "after held req");
`else
    readDisp(0, 48, 16'h1234, "released bank retained lane 0");
    readDisp(0, 95, 16'hFFFF, "released bank retained tile 5");
    readDisp(0, 112, 16'h7777, "released bank retained tile 7");

    busA.swap_req = 1'b1;
    expDisp = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("held req ack every cycle", TW'(busA.swap_ack), TW'(1));
      checkOutput("held req disp_bank", TW'(busA.disp_bank), TW'(expDisp));
      tick();
      expDisp = 1 - expDisp;
    end
    busA.swap_req = 1'b0;
`endif
    checkOutput("after held req disp_bank", TW'(busA.disp_bank), '0);
    checkOutput("after held req draw_bank", TW'(busA.draw_bank), TW'(1));

    applyStimulus(0, 30, fillTile(16'hCAFE), 16'hFFFF);
    readDraw(0, 30, fillTile(16'hCAFE), "pre-reset draw tile 30");
    doSwap(0, 1, 0, "swap before reset");
`ifdef LINEBUF_AUTOCLEAR_EN
    for (int c = 0; c < 20; c++) tick();
`endif
    reset = 1'b1;
    busA.swap_req = 1'b1;
    #1;
    checkOutput("mid reset disp_bank", TW'(busA.disp_bank), '0);
    checkOutput("mid reset draw_bank", TW'(busA.draw_bank), TW'(1));
    checkOutput("mid reset swap_ack", TW'(busA.swap_ack), '0);
    tick();
    busA.swap_req = 1'b0;
    reset = 1'b0;
`ifdef LINEBUF_AUTOCLEAR_EN
    waitLow(40, "re-init");
    checkHigh("re-init done");
    readDraw(0, 30, '0, "re-init cleared bank1 tile 30");
    readDisp(0, 5, 16'h0000, "re-init cleared bank0");
    readDisp(0, 639, 16'h0000, "re-init cleared bank0 end");
`endif

    waitReady(1, 60, "3-bank init");
    doSwap(1, 1, 2, "3-bank swap 1");
    checkOutput("3-bank draw_ready after swap 1", TW'(busB.draw_ready), TW'(1));
    applyStimulus(1, 4, fillTile(16'hC3C3), 16'hFFFF);
    waitReady(1, 60, "3-bank before swap 2");
    doSwap(1, 2, 0, "3-bank swap 2");
    checkOutput("3-bank draw_ready after swap 2", TW'(busB.draw_ready), TW'(1));
    readDisp(1, 64, 16'hC3C3, "3-bank draw during other clear");
    readDisp(1, 79, 16'hC3C3, "3-bank draw during other clear lane 15");
    waitReady(1, 60, "3-bank before swap 3");
    doSwap(1, 0, 1, "3-bank swap 3 wrap");
    checkOutput("3-bank draw_ready after swap 3", TW'(busB.draw_ready), TW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
